// File: rtl/flappy_pkg.sv
// Shared types and game constants for the bird physics block and its
// animation sequencer. Positions are Q10.4 pixels, velocities Q4.4 px/frame.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    localparam int POS_W  = 14;
    localparam int VEL_W  = 8;
    localparam int FRAC_W = 4;

    localparam int START_Y     = 240;
    localparam int GROUND_Y    = 400;
    localparam int BIRD_HEIGHT = 24;
    localparam int GRAVITY     = 4;
    localparam int FLAP_VEL    = -64;
    localparam int MAX_FALL    = 96;
    localparam int ANIM_FRAMES = 6;
    localparam int DEAD_HOLD   = 30;

    localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

    // Sized forms of the constants so the datapath compares like widths.
    localparam logic [POS_W-1:0]          START_POS  = POS_W'(START_Y << FRAC_W);
    localparam logic [POS_W-1:0]          FLOOR_POS  = POS_W'((GROUND_Y - BIRD_HEIGHT) << FRAC_W);
    localparam logic [POS_W-FRAC_W:0]     FLOOR_PX   = (POS_W-FRAC_W+1)'(GROUND_Y - BIRD_HEIGHT);
    localparam logic signed [VEL_W-1:0]   FLAP_V     = VEL_W'(FLAP_VEL);
    localparam logic signed [VEL_W:0]     GRAVITY_V9 = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]     MAX_FALL_V9 = (VEL_W+1)'(MAX_FALL);
    localparam logic [HOLD_W-1:0]         HOLD_MAX   = HOLD_W'(DEAD_HOLD);

endpackage

// File: rtl/anim_seq.sv
// Wing-animation sequencer: a tick-enabled prescaler that advances the
// sprite frame 0 -> 1 -> 2 -> 0 every FRAMES enabled ticks.
module anim_seq
    import flappy_pkg::*;
#(
    parameter int FRAMES = ANIM_FRAMES
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [1:0] frame_o
);

    localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       frame_q;

    // Prescaler and frame counter; clear wins over enable so a restart lands on frame 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            frame_q <= 2'd0;
        end else if (clr_i) begin
            cnt_q   <= '0;
            frame_q <= 2'd0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_q   <= '0;
                frame_q <= (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign frame_o = frame_q;

endmodule

// File: rtl/bird_physics.sv
// Per-frame bird physics and IDLE/PLAY/DEAD game FSM. All state moves only
// on frame_tick_i; only the flap latch samples every cycle.
module bird_physics
    import flappy_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic       flap_i,
    output logic [9:0] bird_y_o,
    output logic [1:0] bird_frame_o,
    output logic [1:0] game_state_o,
    output logic       dead_o
);

    game_state_t              state_q, state_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic signed [VEL_W-1:0]  vel_q, vel_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     flap_pend_q, flap_pend_d;

    logic                     flap_eff;
    logic signed [VEL_W:0]    v_sum;
    logic signed [VEL_W-1:0]  v_grav;
    logic signed [VEL_W-1:0]  v1;
    logic [POS_W:0]           pos_n;
    logic                     anim_en;
    logic                     anim_clr;

    // State, kinematics, dead-hold counter and flap latch registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            pos_q       <= START_POS;
            vel_q       <= '0;
            hold_q      <= '0;
            flap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            hold_q      <= hold_d;
            flap_pend_q <= flap_pend_d;
        end
    end

    // Next-state logic: a flap in the tick cycle itself counts, velocity sums use a guard bit.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        vel_d       = vel_q;
        hold_d      = hold_q;
        anim_clr    = 1'b0;

        flap_eff    = flap_pend_q | flap_i;
        flap_pend_d = frame_tick_i ? 1'b0 : flap_eff;

        v_sum  = {vel_q[VEL_W-1], vel_q} + GRAVITY_V9;
        v_grav = (v_sum > MAX_FALL_V9) ? MAX_FALL_V9[VEL_W-1:0] : v_sum[VEL_W-1:0];
        v1     = flap_eff ? FLAP_V : v_grav;
        pos_n  = {1'b0, pos_q} + {{(POS_W+1-VEL_W){v1[VEL_W-1]}}, v1};

        anim_en = frame_tick_i && ((state_q == IDLE) || (state_q == PLAY));

        if (frame_tick_i) begin
            case (state_q)
                IDLE: begin
                    if (flap_eff) begin
                        state_d = PLAY;
                        vel_d   = FLAP_V;
                        pos_d   = pos_n[POS_W-1:0];
                    end
                end
                PLAY: begin
                    if (pos_n[POS_W]) begin
                        pos_d = '0;
                        vel_d = '0;
                    end else if (pos_n[POS_W:FRAC_W] >= FLOOR_PX) begin
                        pos_d   = FLOOR_POS;
                        vel_d   = '0;
                        state_d = DEAD;
                        hold_d  = '0;
                    end else begin
                        pos_d = pos_n[POS_W-1:0];
                        vel_d = v1;
                    end
                end
                DEAD: begin
                    if (hold_q == HOLD_MAX) begin
                        if (flap_eff) begin
                            state_d  = IDLE;
                            pos_d    = START_POS;
                            vel_d    = '0;
                            hold_d   = '0;
                            anim_clr = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    pos_d    = START_POS;
                    vel_d    = '0;
                    hold_d   = '0;
                    anim_clr = 1'b1;
                end
            endcase
        end
    end

    anim_seq #(
        .FRAMES (ANIM_FRAMES)
    ) u_anim_seq (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (anim_en),
        .clr_i   (anim_clr),
        .frame_o (bird_frame_o)
    );

    assign bird_y_o     = pos_q[POS_W-1:FRAC_W];
    assign game_state_o = state_q;
    assign dead_o       = (state_q == DEAD);

endmodule
